// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the synchronous-read CPU memory between the 6502 core (port 0)
// and the loader/debug DMA (port 1): round-robin, bounded locked bursts, read return, range reject.
package mem_arbiter_pkg;
  typedef enum logic {MW_READ = 1'b0, MW_WRITE = 1'b1} mw_t;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

// state   | meaning
// IDLE    | nobody won last cycle, or the winner did not ask to lock
// OWN0    | port 0 won last cycle with lock set; it keeps priority until MAX_BURST
// OWN1    | port 1 won last cycle with lock set; it keeps priority until MAX_BURST
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 2048,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  p0_req,
  input  mw_t   p0_mw,
  input  addr_t p0_addr,
  input  data_t p0_wdata,
  input  logic  p0_lock,
  output logic  p0_gnt,
  output logic  p0_rvalid,
  output data_t p0_rdata,
  output logic  p0_err,
  input  logic  p1_req,
  input  mw_t   p1_mw,
  input  addr_t p1_addr,
  input  data_t p1_wdata,
  input  logic  p1_lock,
  output logic  p1_gnt,
  output logic  p1_rvalid,
  output data_t p1_rdata,
  output logic  p1_err,
  output mw_t   mem_mw,
  output addr_t mem_addr,
  output data_t mem_data_in,
  input  data_t mem_data_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} own_e;

  localparam logic [3:0] C_MAX = 4'(MAX_BURST);

  own_e       r_state, w_state_nxt;
  logic [3:0] r_burst, w_burst_nxt;
  logic       r_last, w_last_nxt;
  logic       r_rvalid0, r_rvalid1, r_err0, r_err1;

  logic       w_own_vld, w_own_port;
  logic       w_win_vld, w_win;
  mw_t        w_sel_mw;
  addr_t      w_sel_addr;
  data_t      w_sel_wdata;
  logic       w_sel_lock;
  logic       w_in_range, w_drive;

  assign w_own_vld  = (r_state != ST_IDLE);
  assign w_own_port = (r_state == ST_OWN1);

  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        w_win_vld = 1'b1;
        if (w_own_vld && (r_burst < C_MAX)) w_win = w_own_port;
        else if (w_own_vld)                 w_win = ~w_own_port;
        else                                w_win = ~r_last;
      end else if (p0_req || p1_req) begin
        w_win_vld = 1'b1;
        w_win     = p1_req;
      end
    end
  end

  assign w_sel_mw    = w_win ? p1_mw    : p0_mw;
  assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;
  assign w_sel_lock  = w_win ? p1_lock  : p0_lock;
  assign w_in_range  = (32'(w_sel_addr) < MEM_DEPTH);
  assign w_drive     = w_win_vld && w_in_range;

  assign p0_gnt = w_win_vld && !w_win;
  assign p1_gnt = w_win_vld &&  w_win;

  // Out-of-range or absent accesses park the memory on a harmless read of address 0.
  assign mem_mw      = w_drive ? w_sel_mw    : MW_READ;
  assign mem_addr    = w_drive ? w_sel_addr  : '0;
  assign mem_data_in = w_drive ? w_sel_wdata : '0;

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_burst_nxt = 4'd0;
    w_last_nxt  = r_last;
    if (w_win_vld) begin
      w_last_nxt = w_win;
      if (w_sel_lock) begin
        w_state_nxt = w_win ? ST_OWN1 : ST_OWN0;
        if (r_state == w_state_nxt) w_burst_nxt = (r_burst >= C_MAX) ? C_MAX : r_burst + 4'd1;
        else                        w_burst_nxt = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_burst   <= 4'd0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_burst   <= w_burst_nxt;
      r_last    <= w_last_nxt;
      r_rvalid0 <= w_drive && !w_win && (w_sel_mw == MW_READ);
      r_rvalid1 <= w_drive &&  w_win && (w_sel_mw == MW_READ);
      r_err0    <= w_win_vld && !w_win && !w_in_range;
      r_err1    <= w_win_vld &&  w_win && !w_in_range;
    end
  end

  // A reset arriving while a return is pending kills it in that same cycle, not one later.
  assign p0_rvalid = r_rvalid0 && rst_n;
  assign p1_rvalid = r_rvalid1 && rst_n;
  assign p0_err    = r_err0 && rst_n;
  assign p1_err    = r_err1 && rst_n;
  assign p0_rdata  = mem_data_out;
  assign p1_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table for the documented scenarios, then
// constrained-random traffic checked against a rule-level arbitration/memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MEM_DEPTH = 2048;
  localparam int MAX_BURST = 4;
  localparam mw_t R = MW_READ;
  localparam mw_t W = MW_WRITE;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  req[2];
  mw_t   mw[2];
  addr_t addr[2];
  data_t wdata[2];
  logic  lock[2];
  logic  p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  data_t p0_rdata, p1_rdata;
  mw_t   mem_mw;
  addr_t mem_addr;
  data_t mem_data_in, mem_data_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_mw(mw[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_lock(lock[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_mw(mw[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_lock(lock[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_mw(mem_mw), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Synchronous-read memory; preload pattern is byte(addr*3+1).
  logic  mem_init;
  data_t mem [0:MEM_DEPTH-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'(i * 3 + 1);
    end else begin
      mem_data_out <= mem[mem_addr[10:0]];
      if (mem_mw == MW_WRITE) mem[mem_addr[10:0]] = mem_data_in;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rst;
    bit r0; mw_t m0; addr_t a0; data_t d0; bit l0;
    bit r1; mw_t m1; addr_t a1; data_t d1; bit l1;
    bit g0; bit g1; mw_t emw; addr_t ea; data_t ed;
    bit v0; bit v1; bit e0; bit e1; data_t rd;
  } vec_t;

  function automatic vec_t row(input bit rst, bit r0, mw_t m0, int a0, int d0, bit l0,
                               input bit r1, mw_t m1, int a1, int d1, bit l1,
                               input bit g0, bit g1, mw_t emw, int ea, int ed,
                               input bit v0, bit v1, bit e0, bit e1, int rd);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.m0 = m0; v.a0 = 16'(a0); v.d0 = 8'(d0); v.l0 = l0;
    v.r1 = r1; v.m1 = m1; v.a1 = 16'(a1); v.d1 = 8'(d1); v.l1 = l1;
    v.g0 = g0; v.g1 = g1; v.emw = emw; v.ea = 16'(ea); v.ed = 8'(ed);
    v.v0 = v0; v.v1 = v1; v.e0 = e0; v.e1 = e1; v.rd = 8'(rd);
    return v;
  endfunction

  vec_t tbl[$];

  task automatic apply_vec(input int i);
    vec_t v = tbl[i];
    @(negedge clk);
    rst_n = v.rst;
    req[0] = v.r0; mw[0] = v.m0; addr[0] = v.a0; wdata[0] = v.d0; lock[0] = v.l0;
    req[1] = v.r1; mw[1] = v.m1; addr[1] = v.a1; wdata[1] = v.d1; lock[1] = v.l1;
    #1;
    chk($sformatf("row%0d p0_gnt", i), int'(p0_gnt), int'(v.g0));
    chk($sformatf("row%0d p1_gnt", i), int'(p1_gnt), int'(v.g1));
    chk($sformatf("row%0d mem_mw", i), int'(mem_mw), int'(v.emw));
    chk($sformatf("row%0d mem_addr", i), int'(mem_addr), int'(v.ea));
    chk($sformatf("row%0d mem_data_in", i), int'(mem_data_in), int'(v.ed));
    chk($sformatf("row%0d p0_rvalid", i), int'(p0_rvalid), int'(v.v0));
    chk($sformatf("row%0d p1_rvalid", i), int'(p1_rvalid), int'(v.v1));
    chk($sformatf("row%0d p0_err", i), int'(p0_err), int'(v.e0));
    chk($sformatf("row%0d p1_err", i), int'(p1_err), int'(v.e1));
    if (v.v0) chk($sformatf("row%0d p0_rdata", i), int'(p0_rdata), int'(v.rd));
    if (v.v1) chk($sformatf("row%0d p1_rdata", i), int'(p1_rdata), int'(v.rd));
  endtask

  // Reference model state: current locked holder (-1 none), its streak length, last winner.
  int    own, streak, last;
  bit    pv[2], pe[2], gnt_last[2];
  data_t pd[2];
  data_t ref_mem [0:MEM_DEPTH-1];

  task automatic new_req(input int p);
    req[p]   = ($urandom_range(0, 3) != 0);
    mw[p]    = ($urandom_range(0, 2) == 0) ? W : R;
    addr[p]  = ($urandom_range(0, 3) == 3) ? 16'($urandom_range(16'h07FC, 16'h0803))
                                           : 16'($urandom_range(0, 15));
    wdata[p] = 8'($urandom);
    lock[p]  = ($urandom_range(0, 1) == 1);
  endtask

  task automatic rand_cycle(input int c);
    int    w;
    bit    inr;
    mw_t   emw;
    addr_t ea;
    data_t ed;
    @(negedge clk);
    for (int p = 0; p < 2; p++) if (gnt_last[p] || !req[p]) new_req(p);
    rst_n = ($urandom_range(0, 99) != 0);
    #1;
    w = -1;
    if (rst_n) begin
      if (req[0] && req[1]) begin
        if (own >= 0) w = (streak < MAX_BURST) ? own : 1 - own;
        else          w = 1 - last;
      end else if (req[0]) w = 0;
      else if (req[1])     w = 1;
    end
    inr = 1'b0;
    emw = R; ea = '0; ed = '0;
    if (w >= 0) begin
      inr = (int'(addr[w]) < MEM_DEPTH);
      if (inr) begin emw = mw[w]; ea = addr[w]; ed = wdata[w]; end
    end
    chk($sformatf("rnd%0d p0_gnt", c), int'(p0_gnt), int'(w == 0));
    chk($sformatf("rnd%0d p1_gnt", c), int'(p1_gnt), int'(w == 1));
    chk($sformatf("rnd%0d mem_mw", c), int'(mem_mw), int'(emw));
    chk($sformatf("rnd%0d mem_addr", c), int'(mem_addr), int'(ea));
    chk($sformatf("rnd%0d mem_data_in", c), int'(mem_data_in), int'(ed));
    chk($sformatf("rnd%0d p0_rvalid", c), int'(p0_rvalid), int'(pv[0] && rst_n));
    chk($sformatf("rnd%0d p1_rvalid", c), int'(p1_rvalid), int'(pv[1] && rst_n));
    chk($sformatf("rnd%0d p0_err", c), int'(p0_err), int'(pe[0] && rst_n));
    chk($sformatf("rnd%0d p1_err", c), int'(p1_err), int'(pe[1] && rst_n));
    if (pv[0] && rst_n) chk($sformatf("rnd%0d p0_rdata", c), int'(p0_rdata), int'(pd[0]));
    if (pv[1] && rst_n) chk($sformatf("rnd%0d p1_rdata", c), int'(p1_rdata), int'(pd[1]));
    for (int p = 0; p < 2; p++) begin
      pv[p] = (w == p) && inr && (mw[p] == R);
      pe[p] = (w == p) && !inr;
      if (pv[p]) pd[p] = ref_mem[addr[p][10:0]];
      gnt_last[p] = (w == p);
    end
    if (inr && mw[w] == W) ref_mem[addr[w][10:0]] = wdata[w];
    if (!rst_n) begin
      own = -1; streak = 0; last = 1;
    end else if (w >= 0) begin
      if (lock[w]) begin
        streak = (own == w) ? ((streak < MAX_BURST) ? streak + 1 : MAX_BURST) : 1;
        own    = w;
      end else begin
        own = -1; streak = 0;
      end
      last = w;
    end else begin
      own = -1; streak = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; mw[p] = R; addr[p] = '0; wdata[p] = '0; lock[p] = 1'b0;
    end
    repeat (2) @(negedge clk);
    mem_init = 1'b0;

    // rst r0 m0 a0 d0 l0 | r1 m1 a1 d1 l1 | g0 g1 mw addr din | v0 v1 e0 e1 rdata
    tbl.push_back(row(0, 1,R,'h010,0,0,    0,R,0,0,0,       0,0,R,0,0,       0,0,0,0,0));
    tbl.push_back(row(1, 1,R,'h010,0,0,    1,R,'h020,0,0,   1,0,R,'h010,0,   0,0,0,0,0));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,'h020,0,0,   0,1,R,'h020,0,   1,0,0,0,'h31));
    tbl.push_back(row(1, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,1,0,0,'h61));
    tbl.push_back(row(1, 1,W,'h100,'h5A,0, 0,R,0,0,0,       1,0,W,'h100,'h5A,0,0,0,0,0));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,'h100,0,0,   0,1,R,'h100,0,   0,0,0,0,0));
    tbl.push_back(row(1, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,1,0,0,'h5A));
    tbl.push_back(row(1, 1,R,1,0,0,        1,R,2,0,1,       1,0,R,1,0,       0,0,0,0,0));
    tbl.push_back(row(1, 1,R,3,0,0,        1,R,2,0,1,       0,1,R,2,0,       1,0,0,0,4));
    tbl.push_back(row(1, 1,R,3,0,0,        1,R,2,0,1,       0,1,R,2,0,       0,1,0,0,7));
    tbl.push_back(row(1, 1,R,3,0,0,        1,R,2,0,1,       0,1,R,2,0,       0,1,0,0,7));
    tbl.push_back(row(1, 1,R,3,0,0,        1,R,2,0,1,       0,1,R,2,0,       0,1,0,0,7));
    tbl.push_back(row(1, 1,R,3,0,0,        1,R,2,0,1,       1,0,R,3,0,       0,1,0,0,7));
    tbl.push_back(row(1, 1,R,4,0,0,        1,R,2,0,0,       0,1,R,2,0,       1,0,0,0,10));
    tbl.push_back(row(1, 1,R,4,0,0,        1,R,5,0,0,       1,0,R,4,0,       0,1,0,0,7));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,5,0,0,       0,1,R,5,0,       1,0,0,0,13));
    tbl.push_back(row(1, 1,R,'h800,0,0,    0,R,0,0,0,       1,0,R,0,0,       0,1,0,0,16));
    tbl.push_back(row(1, 0,R,0,0,0,        1,W,'h900,'hEE,0,0,1,R,0,0,       0,0,1,0,0));
    tbl.push_back(row(1, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,0,0,1,0));
    tbl.push_back(row(1, 1,R,'h7FF,0,0,    0,R,0,0,0,       1,0,R,'h7FF,0,   0,0,0,0,0));
    tbl.push_back(row(1, 1,R,1,0,0,        0,R,0,0,0,       1,0,R,1,0,       1,0,0,0,'hFE));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,2,0,0,       0,1,R,2,0,       1,0,0,0,4));
    tbl.push_back(row(1, 1,R,3,0,0,        0,R,0,0,0,       1,0,R,3,0,       0,1,0,0,7));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,4,0,0,       0,1,R,4,0,       1,0,0,0,10));
    tbl.push_back(row(1, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,1,0,0,13));
    tbl.push_back(row(1, 1,R,'h010,0,0,    0,R,0,0,0,       1,0,R,'h010,0,   0,0,0,0,0));
    tbl.push_back(row(0, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,0,0,0,0));
    tbl.push_back(row(1, 1,R,1,0,0,        1,R,2,0,0,       1,0,R,1,0,       0,0,0,0,0));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,2,0,0,       0,1,R,2,0,       1,0,0,0,4));
    tbl.push_back(row(1, 0,R,0,0,0,        1,R,0,0,0,       0,1,R,0,0,       0,1,0,0,7));
    tbl.push_back(row(1, 0,R,0,0,0,        0,R,0,0,0,       0,0,R,0,0,       0,1,0,0,1));
    for (int i = 0; i < tbl.size(); i++) apply_vec(i);

    // Random phase starts from a fresh reset with the model mirroring the memory image.
    @(negedge clk);
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; pv[p] = 1'b0; pe[p] = 1'b0; pd[p] = '0; gnt_last[p] = 1'b0;
    end
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = mem[i];
    own = -1; streak = 0; last = 1;
    for (int c = 0; c < 2000; c++) rand_cycle(c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port, synchronous-read CPU memory between two requesters.
- Port 0 is the 6502 core. Port 1 is the loader/debug DMA.
- Sits between both requesters and the memory. Only this block drives the memory mw/addr/data lines.
- Provides round-robin fairness, bounded locked bursts, read-data return routing and out-of-range address rejection.

Parameters:
MEM_DEPTH, 2048, number of valid memory locations; addresses >= MEM_DEPTH are rejected
MAX_BURST, 4, maximum consecutive locked grants to one port while the other port is requesting (1..15)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
p0_req  in  1  port 0 access request, held until granted
p0_mw  in  mw_t  port 0 access type (READ/WRITE)
p0_addr  in  addr_t  port 0 address
p0_wdata  in  data_t  port 0 write data
p0_lock  in  1  port 0 requests to retain ownership on following cycles
p0_gnt  out  1  port 0 access accepted this cycle (combinational)
p0_rvalid  out  1  port 0 read data valid (registered)
p0_rdata  out  data_t  port 0 read data
p0_err  out  1  port 0 access rejected, out of range (registered pulse)
p1_req, p1_mw, p1_addr, p1_wdata, p1_lock, p1_gnt, p1_rvalid, p1_rdata, p1_err  same as port 0, for port 1
mem_mw  out  mw_t  to memory mw
mem_addr  out  addr_t  to memory addr
mem_data_in  out  data_t  to memory data_in
mem_data_out  in  data_t  from memory data_out, valid the cycle after a read is issued

Behaviour:
- Reset (rst_n=0 at posedge):
  - owner state = IDLE; burst count = 0; last_winner = 1, so port 0 wins the first tie.
  - rvalid/err registers = 0 on both ports.
  - p*_gnt = 0 while rst_n=0.
  - mem_mw = READ, mem_addr = 0, mem_data_in = 0.
- Owner FSM: IDLE, OWN0, OWN1; evaluated every cycle.
  - OWNx: port x won last cycle with lock=1.
  - IDLE: no port won last cycle, or the winner had lock=0.
- Winner selection (combinational):
  - Only one requester: it wins.
  - Both requesting, IDLE: port != last_winner wins.
  - Both requesting, OWNx, px_req=1, burst count < MAX_BURST: port x wins.
  - Otherwise: the other port wins.
  - OWNx with px_req=0: ownership released, normal selection applies.
- Grant:
  - Winner's gnt = 1, other gnt = 0. No request means no grant.
  - A request with gnt=0 must be held unchanged by the requester.
- Memory drive, winner in range:
  - mem_mw/mem_addr/mem_data_in = winner's mw/addr/wdata.
- Memory drive, no winner or winner out of range:
  - mem_mw = READ, mem_addr = 0, mem_data_in = 0. No write ever reaches memory.
- Read return:
  - In-range READ granted in cycle N: that port's rvalid = 1 in cycle N+1.
  - p*_rdata = mem_data_out (pass-through) for both ports; meaningful only while rvalid = 1.
  - Owner tag is registered, so back-to-back reads from alternating ports return to the correct port.
- Writes: complete in the grant cycle. No rvalid.
- Out of range (addr >= MEM_DEPTH):
  - Request still granted (consumed).
  - err = 1 in cycle N+1; rvalid stays 0.
- Burst counter (4 bits):
  - Next cycle: OWN(winner) when winner lock=1, else IDLE.
  - Count increments on a repeat grant to the same owner.
  - Count resets to 1 on an owner change, and to 0 when lock drops.
  - Saturates at MAX_BURST. Starvation limit only applies while the other port is requesting.
- last_winner updates on every grant.
- Reset mid-read: a pending rvalid/err is cleared; the access is lost.

Test Plan:
- Reset, then p0 and p1 READ in the same cycle, addr 0x010 / 0x020 -> cycle 0: p0_gnt=1, mem_addr=0x010. Cycle 1: p1_gnt=1, p0_rvalid=1 with mem contents of 0x010. Cycle 2: p1_rvalid=1.
- p0 WRITE 0x5A to 0x100, then p1 READ 0x100 -> no rvalid after the write; p1_rdata=0x5A with p1_rvalid=1 the cycle after its grant.
- p1 lock=1 with continuous requests, p0 continuously requesting, MAX_BURST=4 -> p1 granted 4 consecutive cycles, p0 granted on the 5th, then round-robin resumes.
- p0 READ addr 0x0800 (MEM_DEPTH=2048) -> p0_gnt=1, mem_mw=READ, mem_addr=0. Next cycle p0_err=1, p0_rvalid=0. Memory contents unchanged.
- Alternating p0/p1 reads of 0x001..0x004 every cycle -> every rvalid lands on the issuing port with the correct data; no cycle has both rvalids asserted.
- rst_n=0 in the cycle after a p0 read grant -> p0_rvalid stays 0. After release, port 0 wins the first tie.
